key_entry: RTL
==============

KEY_ENTRY -- requirements
Module: key_entry

Interface
REQ-001 SHALL have parameter HOLD_CYC, default 4: cycles pw_16bit is held stable after enb_cmp before the buffer clears (legal 1..15).
REQ-002 SHALL have parameter AUTO_SUBMIT, default 0: 1 = submit on the 4th digit without key_enter.
REQ-003 SHALL have port clk, input, 1: single system clock; all logic on rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port key_valid, input, 1: one-cycle strobe; key_code is a digit.
REQ-006 SHALL have port key_code, input, 4: hex digit, sampled only when key_valid=1.
REQ-007 SHALL have port key_enter, input, 1: one-cycle submit strobe.
REQ-008 SHALL have port key_clear, input, 1: one-cycle strobe that discards the entry.
REQ-009 SHALL have port gen_stop, input, 1: lockout from the comparator; while 1, all key input is ignored.
REQ-010 SHALL have port pw_16bit, output, 16: assembled password; the first digit ends up in [15:12].
REQ-011 SHALL have port enb_cmp, output, 1: one-cycle compare request to the comparator.
REQ-012 SHALL have port digit_cnt, output, 3: digits currently buffered (0..4).
REQ-013 SHALL have port entry_err, output, 1: one-cycle pulse on a short submit.
REQ-014 SHALL have port busy, output, 1: high in ISSUE and HOLD.

Function
REQ-015 SHALL implement states IDLE, COLLECT, FULL, ISSUE, HOLD.
REQ-016 On an accepted digit, SHALL shift pw_16bit <= {pw_16bit[11:0], key_code} and increment digit_cnt, both registered and visible the next cycle.
REQ-017 IDLE SHALL go to COLLECT on the first accepted digit; COLLECT SHALL go to FULL when digit_cnt becomes 4.
REQ-018 In FULL, key_valid SHALL be ignored: no shift, no count change.
REQ-019 key_enter in FULL SHALL go to ISSUE; enb_cmp SHALL be 1 for exactly the ISSUE cycle, i.e. 1 cycle after the enter strobe.
REQ-020 With AUTO_SUBMIT=1, the 4th digit SHALL go directly to ISSUE, and key_enter in FULL is unreachable.
REQ-021 key_enter in IDLE or COLLECT SHALL pulse entry_err for 1 cycle, clear pw_16bit and digit_cnt to 0, and go to IDLE.
REQ-022 ISSUE SHALL go to HOLD unconditionally after 1 cycle.
REQ-023 HOLD SHALL keep pw_16bit stable for HOLD_CYC cycles using a 4-bit down-counter.
REQ-024 At HOLD expiry, HOLD SHALL clear pw_16bit and digit_cnt and go to IDLE.
REQ-025 In ISSUE and HOLD, all key strobes SHALL be ignored, including key_clear.
REQ-026 key_clear in IDLE, COLLECT or FULL SHALL zero pw_16bit and digit_cnt and go to IDLE, with no entry_err.
REQ-027 Same-cycle strobes SHALL resolve in priority key_clear > key_enter > key_valid; the lower-priority strobes in that cycle are dropped.
REQ-028 gen_stop=1 in any state SHALL, on the next edge, force IDLE and zero pw_16bit and digit_cnt.
REQ-029 gen_stop=1 in the ISSUE state SHALL still let that cycle's enb_cmp pulse complete; no new enb_cmp SHALL then issue while gen_stop=1.
REQ-030 gen_stop falling SHALL require no extra cycle: the next strobe is processed normally.
REQ-031 enb_cmp and entry_err SHALL never be high in the same cycle, and no output SHALL be combinationally dependent on the inputs.

Reset
REQ-032 reset=0 SHALL immediately, asynchronously, set state IDLE, pw_16bit=16'h0000, enb_cmp=0, digit_cnt=0, entry_err=0, busy=0, HOLD counter=0.
REQ-033 Reset deassertion mid-operation SHALL restart from IDLE with no stale digits and no spurious enb_cmp.

Verification
REQ-034 Digits 1,2,3,4 then key_enter -> pw_16bit=16'h1234; enb_cmp 1 cycle after enter; busy for 1+4 cycles; then pw_16bit=0, digit_cnt=0.
REQ-035 Digits 1,2 then key_enter -> entry_err one cycle, no enb_cmp, pw_16bit=0; a fifth digit 5 after 1,2,3,4 -> pw_16bit stays 16'h1234, digit_cnt=4.
REQ-036 key_clear and key_enter in the same cycle in FULL -> IDLE, no enb_cmp, no entry_err.
REQ-037 gen_stop=1 while in COLLECT with 16'h0012, plus digits during lockout -> buffer 0, digit_cnt stays 0; after gen_stop=0, entry 0,0,0,0 + enter -> enb_cmp with pw_16bit=16'h0000.
REQ-038 AUTO_SUBMIT=1, digits A,B,C,D -> enb_cmp the cycle after D with pw_16bit=16'hABCD.
REQ-039 reset pulsed low during HOLD with 16'h1234 -> all outputs 0 immediately, and no enb_cmp after release.

Source files
------------

// File: rtl/key_entry.sv
// key_entry: collects four hex key digits into a password and issues a held compare request.
module key_entry #(
  parameter int HOLD_CYC = 4,
  parameter bit AUTO_SUBMIT = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        key_enter,
  input  logic        key_clear,
  input  logic        gen_stop,
  output logic [15:0] pw_16bit,
  output logic        enb_cmp,
  output logic [2:0]  digit_cnt,
  output logic        entry_err,
  output logic        busy
);
  typedef enum logic [2:0] {IDLE, COLLECT, FULL, ISSUE, HOLD} state_t;
  state_t state, state_n;
  logic [15:0] pw_n;
  logic [2:0] cnt_n;
  logic [3:0] hold_cnt, hold_n;
  logic err_n;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      pw_16bit <= '0;
      digit_cnt <= '0;
      hold_cnt <= '0;
      entry_err <= 1'b0;
    end else begin
      state <= state_n;
      pw_16bit <= pw_n;
      digit_cnt <= cnt_n;
      hold_cnt <= hold_n;
      entry_err <= err_n;
    end
  end
  always_comb begin
    state_n = state;
    pw_n = pw_16bit;
    cnt_n = digit_cnt;
    hold_n = hold_cnt;
    err_n = 1'b0;
    if (gen_stop) begin
      state_n = IDLE;
      pw_n = '0;
      cnt_n = '0;
      hold_n = '0;
    end else begin
      case (state)
        ISSUE: begin
          state_n = HOLD;
          hold_n = 4'(HOLD_CYC);
        end
        HOLD: begin
          if (hold_cnt <= 4'd1) begin
            state_n = IDLE;
            pw_n = '0;
            cnt_n = '0;
            hold_n = '0;
          end else
            hold_n = hold_cnt - 4'd1;
        end
        default: begin
          if (key_clear) begin
            state_n = IDLE;
            pw_n = '0;
            cnt_n = '0;
          end else if (key_enter) begin
            if (state == FULL)
              state_n = ISSUE;
            else begin
              state_n = IDLE;
              pw_n = '0;
              cnt_n = '0;
              err_n = 1'b1;
            end
          end else if (key_valid && state != FULL) begin
            pw_n = {pw_16bit[11:0], key_code};
            cnt_n = digit_cnt + 3'd1;
            state_n = digit_cnt == 3'd3 ? (AUTO_SUBMIT ? ISSUE : FULL) : COLLECT;
          end
        end
      endcase
    end
  end
  assign enb_cmp = state == ISSUE;
  assign busy = state == ISSUE || state == HOLD;
endmodule
